// File: rtl/soma_rr_arbiter_if.sv
// soma_rr_arbiter_if: request/response bundle; slave = arbiter (takes req_valid/req_a/req_b/resp_ready, drives req_ready/resp_*/ovf_count), master = agents
interface soma_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int OVF_W = 8,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [WIDTH-1:0]       resp_sum;
  logic                   resp_overflow;
  logic [ID_W-1:0]        resp_id;
  logic [OVF_W-1:0]       ovf_count;
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_overflow, resp_id, ovf_count
  );
  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_overflow, resp_id, ovf_count
  );
endinterface

// File: rtl/soma_rr_arbiter.sv
// soma_rr_arbiter: round-robin share of one ripple-carry adder; ports clk, rst (sync high), bus (slave: req_* in/ready out, registered resp_* and saturating ovf_count out)
module soma_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int OVF_W = 8
) (
  input logic clk,
  input logic rst,
  soma_rr_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, grant;
  logic any_valid, accept, ovf, c, c_msb;
  logic [WIDTH-1:0] op_a, op_b, sum;
  always_comb begin
    grant = rr_ptr;
    any_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      grant = (!any_valid && bus.req_valid[ID_W'((int'(rr_ptr) + k) % N_REQ)]) ? ID_W'((int'(rr_ptr) + k) % N_REQ) : grant;
      any_valid = any_valid || bus.req_valid[ID_W'((int'(rr_ptr) + k) % N_REQ)];
    end
  end
  assign accept = state == IDLE && !rst && any_valid;
  assign op_a = bus.req_a[grant*WIDTH +: WIDTH];
  assign op_b = bus.req_b[grant*WIDTH +: WIDTH];
  always_comb begin
    sum = '0;
    c = 1'b0;
    c_msb = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = op_a[i] ^ op_b[i] ^ c;
      c_msb = (i == WIDTH-1) ? c : c_msb;
      c = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
    end
    ovf = c ^ c_msb;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? (accept ? RESP : IDLE) : (bus.resp_ready ? IDLE : RESP);
  always_comb
    bus.req_ready = accept ? N_REQ'(1) << grant : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_sum <= '0;
      bus.resp_overflow <= 1'b0;
      bus.resp_id <= '0;
      bus.ovf_count <= '0;
    end else if (accept) begin
      rr_ptr <= (grant == ID_W'(N_REQ-1)) ? '0 : grant + 1'b1;
      bus.resp_valid <= 1'b1;
      bus.resp_sum <= sum;
      bus.resp_overflow <= ovf;
      bus.resp_id <= grant;
      bus.ovf_count <= bus.ovf_count + OVF_W'(ovf && !(&bus.ovf_count));
    end else if (state == RESP && bus.resp_ready) begin
      bus.resp_valid <= 1'b0;
    end
  end
endmodule
